tlb_replace_ctrl: RTL and testbench

TLB_REPLACE_CTRL -- requirements
Module: tlb_replace_ctrl

---
 rtl/tlb_pkg.sv | 13 +
 rtl/tlb_victim_cmp.sv | 31 +++
 rtl/tlb_replace_ctrl.sv | 179 +++++++++++++++++
 tb/tb_tlb_replace_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared constants and FSM encoding for the TLB replacement controller.
package tlb_pkg;

    localparam int unsigned TLB_ENTRY_NUM = 4;
    localparam int unsigned TLB_CNT_W     = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        OUT  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/tlb_victim_cmp.sv
// Two-way replacement compare: invalid beats valid, non-global beats global,
// lower count wins, and a count tie goes to the b (higher-index) input.
module tlb_victim_cmp
    import tlb_pkg::*;
#(
    parameter int unsigned CNT_W = TLB_CNT_W
) (
    input  logic             a_valid,
    input  logic             a_g,
    input  logic [CNT_W-1:0] a_cnt,
    input  logic             b_valid,
    input  logic             b_g,
    input  logic [CNT_W-1:0] b_cnt,
    output logic             pick_b
);

    always_comb begin
        pick_b = 1'b0;
        if (a_valid != b_valid) begin
            pick_b = !b_valid;
        end else if (!a_valid) begin
            // Both empty: fill the lower index first.
            pick_b = 1'b0;
        end else if (a_g != b_g) begin
            pick_b = !b_g;
        end else begin
            pick_b = (b_cnt <= a_cnt);
        end
    end

endmodule

// File: rtl/tlb_replace_ctrl.sv
// Access-count based victim selection for a 4-entry TLB.
// Optional count aging is enabled by defining TLB_ACC_AGING_EN.
module tlb_replace_ctrl
    import tlb_pkg::*;
#(
    parameter int unsigned ENTRY_NUM  = TLB_ENTRY_NUM,
    parameter int unsigned CNT_W      = TLB_CNT_W,
    parameter int unsigned AGE_PERIOD = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hit_valid,
    input  logic [1:0]           hit_id,
    input  logic                 refill_req,
    input  logic                 refill_done,
    input  logic                 refill_G,
    input  logic                 flush_all,
    input  logic                 flush_nonglobal,
    output logic [ENTRY_NUM-1:0] entry_valid,
    output logic                 victim_valid,
    output logic [1:0]           victim_id,
    output logic                 busy
);

    fsm_state_t           state;
    logic [ENTRY_NUM-1:0] g_bit;
    logic [CNT_W-1:0]     cnt     [ENTRY_NUM];
    logic [CNT_W-1:0]     cnt_nxt [ENTRY_NUM];

    logic             pick01, pick23, pick_fin;
    logic             w0_valid, w0_g, w1_valid, w1_g;
    logic [CNT_W-1:0] w0_cnt, w1_cnt;
    logic             p0_lo, p0_valid, p0_g;
    logic             p1_lo, p1_valid, p1_g;
    logic [CNT_W-1:0] p0_cnt, p1_cnt;
    logic [1:0]       fin_id;
    logic             flush_any, refill_fire;

    assign flush_any   = flush_all | flush_nonglobal;
    assign refill_fire = (state == OUT) && refill_done && !flush_any;

`ifdef TLB_ACC_AGING_EN
    localparam int unsigned AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
    logic [AGE_W-1:0] age_cnt;
    logic             age_tick;

    assign age_tick = (age_cnt == AGE_W'(AGE_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst || age_tick) begin
            age_cnt <= '0;
        end else begin
            age_cnt <= age_cnt + AGE_W'(1);
        end
    end
`else
    if (AGE_PERIOD == 0) begin : g_age_period_unused
    end
`endif

    // Aging shift first, then a hit adds one on top of the shifted value.
    always_comb begin
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            cnt_nxt[i] = cnt[i];
`ifdef TLB_ACC_AGING_EN
            if (age_tick) cnt_nxt[i] = cnt[i] >> 1;
`endif
            if (hit_valid && hit_id == 2'(i) && entry_valid[i] && cnt_nxt[i] != '1)
                cnt_nxt[i] = cnt_nxt[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_valid <= '0;
            g_bit       <= '0;
            for (int unsigned i = 0; i < ENTRY_NUM; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                if (flush_all || (flush_nonglobal && !g_bit[i])) begin
                    entry_valid[i] <= 1'b0;
                    cnt[i]         <= '0;
                end else if (refill_fire && victim_id == 2'(i)) begin
                    entry_valid[i] <= 1'b1;
                    g_bit[i]       <= refill_G;
                    cnt[i]         <= CNT_W'(1);
                end else begin
                    cnt[i] <= cnt_nxt[i];
                end
            end
        end
    end

    tlb_victim_cmp #(.CNT_W(CNT_W)) u_cmp01 (
        .a_valid(entry_valid[0]), .a_g(g_bit[0]), .a_cnt(cnt[0]),
        .b_valid(entry_valid[1]), .b_g(g_bit[1]), .b_cnt(cnt[1]),
        .pick_b (pick01)
    );

    tlb_victim_cmp #(.CNT_W(CNT_W)) u_cmp23 (
        .a_valid(entry_valid[2]), .a_g(g_bit[2]), .a_cnt(cnt[2]),
        .b_valid(entry_valid[3]), .b_g(g_bit[3]), .b_cnt(cnt[3]),
        .pick_b (pick23)
    );

    always_comb begin
        w0_valid = pick01 ? entry_valid[1] : entry_valid[0];
        w0_g     = pick01 ? g_bit[1]       : g_bit[0];
        w0_cnt   = pick01 ? cnt[1]         : cnt[0];
        w1_valid = pick23 ? entry_valid[3] : entry_valid[2];
        w1_g     = pick23 ? g_bit[3]       : g_bit[2];
        w1_cnt   = pick23 ? cnt[3]         : cnt[2];
    end

    // Final stage compares the snapshots taken on entry to SEL, not live counts.
    tlb_victim_cmp #(.CNT_W(CNT_W)) u_cmp_fin (
        .a_valid(p0_valid), .a_g(p0_g), .a_cnt(p0_cnt),
        .b_valid(p1_valid), .b_g(p1_g), .b_cnt(p1_cnt),
        .pick_b (pick_fin)
    );

    assign fin_id = pick_fin ? {1'b1, p1_lo} : {1'b0, p0_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            victim_valid <= 1'b0;
            victim_id    <= '0;
            busy         <= 1'b0;
            p0_lo        <= 1'b0;
            p0_valid     <= 1'b0;
            p0_g         <= 1'b0;
            p0_cnt       <= '0;
            p1_lo        <= 1'b0;
            p1_valid     <= 1'b0;
            p1_g         <= 1'b0;
            p1_cnt       <= '0;
        end else if (flush_any) begin
            state        <= IDLE;
            victim_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (refill_req) begin
                        state    <= SEL;
                        busy     <= 1'b1;
                        p0_lo    <= pick01;
                        p0_valid <= w0_valid;
                        p0_g     <= w0_g;
                        p0_cnt   <= w0_cnt;
                        p1_lo    <= pick23;
                        p1_valid <= w1_valid;
                        p1_g     <= w1_g;
                        p1_cnt   <= w1_cnt;
                    end
                end
                SEL: begin
                    state        <= OUT;
                    victim_valid <= 1'b1;
                    victim_id    <= fin_id;
                end
                OUT: begin
                    if (refill_done || !refill_req) begin
                        state        <= IDLE;
                        victim_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    victim_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_replace_ctrl.sv
// Directed bench for tlb_replace_ctrl; the aging sequence runs when TLB_ACC_AGING_EN is defined.
module tb_tlb_replace_ctrl;

`ifdef TLB_ACC_AGING_EN
    localparam int unsigned AGE_P = 8;
`else
    localparam int unsigned AGE_P = 1024;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hit_valid = 1'b0;
    logic [1:0] hit_id = '0;
    logic       refill_req = 1'b0;
    logic       refill_done = 1'b0;
    logic       refill_G = 1'b0;
    logic       flush_all = 1'b0;
    logic       flush_nonglobal = 1'b0;
    logic [3:0] entry_valid;
    logic       victim_valid;
    logic [1:0] victim_id;
    logic       busy;

    int checks = 0;
    int errors = 0;

    tlb_replace_ctrl #(
        .ENTRY_NUM (4),
        .CNT_W     (12),
        .AGE_PERIOD(AGE_P)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hit_valid      (hit_valid),
        .hit_id         (hit_id),
        .refill_req     (refill_req),
        .refill_done    (refill_done),
        .refill_G       (refill_G),
        .flush_all      (flush_all),
        .flush_nonglobal(flush_nonglobal),
        .entry_valid    (entry_valid),
        .victim_valid   (victim_valid),
        .victim_id      (victim_id),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic hit(input logic [1:0] id, input int n);
        hit_valid = 1'b1;
        hit_id    = id;
        repeat (n) step();
        hit_valid = 1'b0;
    endtask

    task automatic chk_cnts(input string tag, input int c0, input int c1, input int c2, input int c3);
        chk({tag, "_c0"}, 32'(dut.cnt[0]), c0);
        chk({tag, "_c1"}, 32'(dut.cnt[1]), c1);
        chk({tag, "_c2"}, 32'(dut.cnt[2]), c2);
        chk({tag, "_c3"}, 32'(dut.cnt[3]), c3);
    endtask

    task automatic do_refill(input string tag, input logic g, input logic [1:0] exp_id);
        refill_req = 1'b1;
        step();
        chk({tag, "_sel_busy"}, 32'(busy), 1);
        chk({tag, "_sel_vv"}, 32'(victim_valid), 0);
        step();
        chk({tag, "_out_vv"}, 32'(victim_valid), 1);
        chk({tag, "_out_id"}, 32'(victim_id), 32'(exp_id));
        refill_done = 1'b1;
        refill_G    = g;
        step();
        refill_done = 1'b0;
        refill_req  = 1'b0;
        refill_G    = 1'b0;
        chk({tag, "_done_busy"}, 32'(busy), 0);
        chk({tag, "_done_vv"}, 32'(victim_valid), 0);
    endtask

    initial begin
        step();
        do_reset();
        chk("rst_entry_valid", 32'(entry_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vv", 32'(victim_valid), 0);
        chk("rst_vid", 32'(victim_id), 0);

`ifdef TLB_ACC_AGING_EN
        begin
            int k;
            do_refill("afill0", 1'b0, 2'd0);
            do_refill("afill1", 1'b0, 2'd1);
            do_refill("afill2", 1'b0, 2'd2);
            do_refill("afill3", 1'b0, 2'd3);
            k = 0;
            while (dut.age_tick !== 1'b1 && k < 20) begin
                step();
                k++;
            end
            chk("age_align", 32'(k < 20), 1);
            step();
            chk_cnts("age_zero", 0, 0, 0, 0);
            hit(2'd0, 4);
            hit(2'd1, 2);
            hit(2'd2, 1);
            chk_cnts("age_pre", 4, 2, 1, 0);
            hit(2'd0, 1);
            chk_cnts("age_shift_hit", 3, 1, 0, 0);
            repeat (8) step();
            chk_cnts("age_idle", 1, 0, 0, 0);
        end
`else
        // All empty: victim 0, two cycles after the request.
        refill_req = 1'b1;
        step();
        chk("s1_sel_busy", 32'(busy), 1);
        chk("s1_sel_vv", 32'(victim_valid), 0);
        step();
        chk("s1_out_vv", 32'(victim_valid), 1);
        chk("s1_out_id", 32'(victim_id), 0);
        step();
        chk("s1_hold_vv", 32'(victim_valid), 1);
        chk("s1_hold_id", 32'(victim_id), 0);
        refill_req = 1'b0;
        step();
        chk("s1_abort_busy", 32'(busy), 0);
        chk("s1_abort_ev", 32'(entry_valid), 0);

        hit(2'd1, 1);
        chk("hit_invalid_cnt", 32'(dut.cnt[1]), 0);
        refill_done = 1'b1;
        step();
        refill_done = 1'b0;
        chk("done_idle_ev", 32'(entry_valid), 0);
        chk("done_idle_busy", 32'(busy), 0);

        do_refill("fill0", 1'b0, 2'd0);
        do_refill("fill1", 1'b0, 2'd1);
        do_refill("fill2", 1'b0, 2'd2);
        do_refill("fill3", 1'b0, 2'd3);
        chk("fill_ev", 32'(entry_valid), 32'hf);

        hit(2'd0, 4);
        hit(2'd1, 1);
        hit(2'd2, 8);
        hit(2'd3, 1);
        chk_cnts("s2_cnts", 5, 2, 9, 2);
        // Refill entry 3 while it is also being hit: refill count wins.
        refill_req = 1'b1;
        step();
        step();
        chk("s2_vid", 32'(victim_id), 3);
        refill_done = 1'b1;
        hit_valid   = 1'b1;
        hit_id      = 2'd3;
        step();
        refill_done = 1'b0;
        hit_valid   = 1'b0;
        refill_req  = 1'b0;
        chk("s2_refill_over_hit", 32'(dut.cnt[3]), 1);

        flush_all = 1'b1;
        step();
        flush_all = 1'b0;
        chk("flush_all_ev", 32'(entry_valid), 0);
        chk("flush_all_c2", 32'(dut.cnt[2]), 0);

        do_refill("g0", 1'b1, 2'd0);
        do_refill("g1", 1'b1, 2'd1);
        do_refill("g2", 1'b0, 2'd2);
        do_refill("g3", 1'b1, 2'd3);
        hit(2'd2, 10);
        refill_req = 1'b1;
        step();
        step();
        chk("s3_vv", 32'(victim_valid), 1);
        chk("s3_vid", 32'(victim_id), 2);

        flush_nonglobal = 1'b1;
        refill_done     = 1'b1;
        refill_G        = 1'b1;
        step();
        flush_nonglobal = 1'b0;
        refill_done     = 1'b0;
        refill_G        = 1'b0;
        refill_req      = 1'b0;
        chk("fng_ev", 32'(entry_valid), 32'hb);
        chk("fng_busy", 32'(busy), 0);
        chk("fng_vv", 32'(victim_valid), 0);
        chk("fng_c2", 32'(dut.cnt[2]), 0);

        refill_req = 1'b1;
        step();
        step();
        chk("ab_vid", 32'(victim_id), 2);
        refill_req = 1'b0;
        step();
        chk("ab_busy", 32'(busy), 0);
        chk("ab_ev", 32'(entry_valid), 32'hb);

        refill_req = 1'b1;
        step();
        chk("mid_sel_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        refill_req = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ev", 32'(entry_valid), 0);
        chk("mid_rst_vv", 32'(victim_valid), 0);
        chk("mid_rst_vid", 32'(victim_id), 0);

        do_refill("sat_fill", 1'b0, 2'd0);
        hit(2'd0, 4094);
        chk("sat_max", 32'(dut.cnt[0]), 4095);
        hit(2'd0, 3);
        chk("sat_hold", 32'(dut.cnt[0]), 4095);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
